// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the sequence-detector scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int FRAME_LEN = 4;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one external 4-bit serial sequence detector between N_REQ requesters.
// Optional per-requester match counters are built when SEQ_SCHED_STATS_EN is defined.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8,
  localparam int ID_W     = clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*FRAME_LEN-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_match,
  input  logic                       rsp_ready,
  output logic                       det_rst_n,
  output logic                       det_in,
  input  logic                       det_dec,
  output logic                       busy,
  output logic [1:0]                 dbg_state
`ifdef SEQ_SCHED_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]     match_cnt
`endif
);

  localparam int BC_W = clog2(FRAME_LEN);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);

  if (N_REQ < 2 || N_REQ > 4 || CNT_W < 1 || FRAME_LEN != seq_sched_pkg::FRAME_LEN) begin : g_bad_cfg
    $error("seq_detect_scheduler: unsupported parameter set");
  end

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shreg;
  logic [BC_W-1:0]      bit_cnt;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      next_ptr;
  logic [N_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_found;
  logic                 accept;
  logic                 rsp_done;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Both handshakes complete on a cycle where valid and ready are high together;
  // neither ready depends on the other side's ready.
  assign accept    = rst_n && (state_q == IDLE) && arb_found;
  assign rsp_done  = (state_q == RESP) && rsp_ready;
  assign req_ready = (rst_n && state_q == IDLE) ? arb_grant : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // The detector is only released while shifting, so every frame starts it fresh.
  assign det_rst_n = rst_n && (state_q == SHIFT);
  assign det_in    = (state_q == SHIFT) ? shreg[FRAME_LEN-1] : 1'b0;

  assign next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      gnt_id    <= '0;
      rr_ptr    <= '0;
      rsp_id    <= '0;
      rsp_match <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg   <= req_data[arb_idx*FRAME_LEN +: FRAME_LEN];
            gnt_id  <= arb_idx;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
          bit_cnt <= bit_cnt + BC_W'(1);
          // Mealy output is valid in the same cycle the last bit is presented.
          if (bit_cnt == LAST_BIT) begin
            rsp_id    <= gnt_id;
            rsp_match <= det_dec;
          end
        end
        RESP: begin
          if (rsp_ready) rr_ptr <= next_ptr;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_SCHED_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (rsp_done && rsp_match && rsp_id == ID_W'(i) && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign match_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler with a behavioural detector and scheduler model.
module tb_seq_detect_scheduler;

  localparam int N     = 2;
  localparam int CNT_W = 2;
  localparam int ID_W  = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*4-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_match;
  logic             rsp_ready;
  logic             det_rst_n;
  logic             det_in;
  logic             det_dec;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef SEQ_SCHED_STATS_EN
  logic [N*CNT_W-1:0] match_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_scheduler #(
    .N_REQ     (N),
    .FRAME_LEN (4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_match (rsp_match),
    .rsp_ready (rsp_ready),
    .det_rst_n (det_rst_n),
    .det_in    (det_in),
    .det_dec   (det_dec),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef SEQ_SCHED_STATS_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  function automatic logic is_pat(input logic [3:0] f);
    return (f == 4'b1001) || (f == 4'b0111) || (f == 4'b1110);
  endfunction

  // External detector: remembers bits since its reset, flags a pattern on the 4th bit.
  logic [2:0] d_hist;
  logic [2:0] d_cnt;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      d_hist <= '0;
      d_cnt  <= '0;
    end else begin
      d_hist <= {d_hist[1:0], det_in};
      if (d_cnt < 3'd4) d_cnt <= d_cnt + 3'd1;
    end
  end
  assign det_dec = det_rst_n && (d_cnt == 3'd3) && is_pat({d_hist, det_in});

  // Reference model: m_age counts cycles since accept (0 = nothing in flight).
  int              m_age = 0;
  int              m_ptr = 0;
  int              m_id  = 0;
  logic [3:0]      m_frame = '0;
  logic [ID_W-1:0] m_rsp_id = '0;
  logic            m_rsp_match = 1'b0;
  logic [CNT_W-1:0] m_cnt [N];
  logic [ID_W:0]   exp_q[$];

  initial for (int i = 0; i < N; i++) m_cnt[i] = '0;

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int g;
    if (!rst_n) begin
      m_age = 0; m_ptr = 0; m_rsp_id = '0; m_rsp_match = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
    end else if (m_age == 0) begin
      g = exp_grant(req_valid);
      if (g >= 0) begin
        m_id    = g;
        m_frame = req_data[4*g +: 4];
        exp_q.push_back({ID_W'(g), is_pat(m_frame)});
        m_age   = 1;
      end
    end else if (m_age < 4) begin
      m_age++;
    end else if (m_age == 4) begin
      m_rsp_id    = ID_W'(m_id);
      m_rsp_match = is_pat(m_frame);
      m_age       = 5;
    end else if (rsp_ready) begin
      if (exp_q.size() > 0) exp_q.delete(0);
      if (m_rsp_match && m_cnt[m_id] != '1) m_cnt[m_id] = m_cnt[m_id] + CNT_W'(1);
      m_ptr = (m_id + 1) % N;
      m_age = 0;
    end
  endtask

  task automatic check_outputs();
    int           g;
    logic [N-1:0] er;
    logic         shifting;
    g        = exp_grant(req_valid);
    er       = '0;
    if (rst_n && m_age == 0 && g >= 0) er[g] = 1'b1;
    shifting = (m_age >= 1) && (m_age <= 4);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_age == 5));
    chk("det_rst_n", 32'(det_rst_n), 32'(rst_n && shifting));
    chk("det_in", 32'(det_in), shifting ? 32'(m_frame[4-m_age]) : 32'd0);
    chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    chk("rsp_match", 32'(rsp_match), 32'(m_rsp_match));
    if (m_age == 5) begin
      chk("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) chk("sb_rsp", 32'({rsp_id, rsp_match}), 32'(exp_q[0]));
    end
`ifdef SEQ_SCHED_STATS_EN
    for (int i = 0; i < N; i++) chk("match_cnt", 32'(match_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
`endif
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [3:0] rand_nib();
    case ($urandom_range(0, 3))
      0:       return 4'b1001;
      1:       return 4'b0111;
      2:       return 4'b1110;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_match", 32'(rsp_match), 32'd0);
    chk("rst_det_in", 32'(det_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Frame 1001 from requester 0 matches.
    req_data = {4'b0000, 4'b1001}; req_valid = 2'b01;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_match", 32'(rsp_match), 32'd1);
    cycle();

    // Frame 1010 from requester 1 does not match.
    req_data = {4'b1010, 4'b0000}; req_valid = 2'b10;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t2_id", 32'(rsp_id), 32'd1);
    chk("t2_match", 32'(rsp_match), 32'd0);
    chk("t2_det_rst_n", 32'(det_rst_n), 32'd0);
    cycle();

    // Both requesters after reset: 0 first, then 1.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req_data = {4'b1110, 4'b0111}; req_valid = 2'b11;
    cycle();
    req_valid = 2'b10;
    repeat (4) cycle();
    chk("t3_first_id", 32'(rsp_id), 32'd0);
    chk("t3_first_match", 32'(rsp_match), 32'd1);
    cycle();
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("t3_second_id", 32'(rsp_id), 32'd1);
    chk("t3_second_match", 32'(rsp_match), 32'd1);
    cycle();

    // Consumer stalls three cycles; other requesters wait.
    req_data = {4'b0000, 4'($urandom_range(0, 15))}; req_valid = 2'b01; rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    req_valid = 2'b11;
    repeat (3) cycle();
    req_valid = '0; rsp_ready = 1'b1;
    cycle();
    chk("t4_done", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a frame drops it.
    req_data = {4'b0000, 4'b1001}; req_valid = 2'b01;
    cycle();
    req_valid = '0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_det_rst_n", 32'(det_rst_n), 32'd0);
    repeat (6) cycle();

    // Random traffic, stalls and occasional resets.
    repeat (600) begin
      req_valid = N'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) req_data[4*i +: 4] = rand_nib();
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (8) cycle();

`ifdef SEQ_SCHED_STATS_EN
    // Five matching frames saturate a 2-bit counter at 3.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (5) begin
      req_data = {4'b0000, 4'b1001}; req_valid = 2'b01;
      cycle();
      req_valid = '0;
      repeat (5) cycle();
    end
    chk("t6_cnt0", 32'(match_cnt[CNT_W-1:0]), 32'd3);
    chk("t6_cnt1", 32'(match_cnt[2*CNT_W-1:CNT_W]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
